// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Clock cycles per bit; the transmit side uses the same rounding (truncation).
    function automatic int calc_div(input longint clk_hz, input longint baud);
        return int'(clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with show-ahead output; full/empty from pointers one bit wider than the address.
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive front end: 2-flop synchroniser, mid-bit sampling FSM, valid/ready byte output.
// Build option UART_RX_FIFO_EN selects a FIFO_DEPTH-entry byte FIFO instead of a single holding register.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DIV        = calc_div(CLK_HZ, BAUD),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 uart_line_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_deframer: DIV must be at least 4");
        end
        // Validated in both builds so a bad depth is caught before the FIFO is switched on.
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_rx_deframer: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rx;
    rx_state_e            state_q;
    logic [DIV_W-1:0]     div_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 push;
    logic                 pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_line_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx = sync2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (!rx) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (div_q == HALF_LAST) begin
                        div_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx ? IDLE : DATA;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                DATA: begin
                    if (div_q == DIV_LAST) begin
                        div_q            <= '0;
                        shift_q[bit_idx_q] <= rx;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                STOP: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (rx) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line must go high before another start bit is accepted.
                    div_q <= '0;
                    if (rx) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    div_q   <= '0;
                end
            endcase
        end
    end

    // The stop-bit sample and the buffer write share an edge, so out_valid rises one cycle later.
    assign push = (state_q == STOP) && (div_q == DIV_LAST) && rx;
    assign pop  = out_valid && out_ready;

`ifdef UART_RX_FIFO_EN
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .din_i   (shift_q),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_dout;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && fifo_full && !pop;
        end
    end
`else
    logic                 hold_valid_q;
    logic [DATA_BITS-1:0] hold_data_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= push && hold_valid_q && !pop;
            if (push && (!hold_valid_q || pop)) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= shift_q;
            end else if (pop) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = hold_valid_q;
    assign out_data  = hold_data_q;
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
